// File: rtl/ble_cmd_encoder.sv
// Serialises HM-10 AT commands (AT, AT+CON<mac>, AT+RESET, AT+ROLE<n>) into a
// byte stream for a UART transmitter, followed by a programmable idle gap.
module ble_cmd_encoder #(
    parameter bit          APPEND_CRLF = 1'b0,
    parameter int unsigned GAP_W       = 24,
    parameter int unsigned GAP_CYCLES  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_sel,
    input  logic [47:0] cmd_mac,
    input  logic [7:0]  cmd_arg,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        err_arg
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    // Command prefixes, left-aligned so byte 0 sits in the top octet.
    localparam logic [63:0] S_AT    = {"AT", 48'h0};
    localparam logic [63:0] S_CON   = {"AT+CON", 16'h0};
    localparam logic [63:0] S_RESET = "AT+RESET";
    localparam logic [63:0] S_ROLE  = {"AT+ROLE", 8'h0};

    localparam logic [4:0]       CRLF_LEN = APPEND_CRLF ? 5'd2 : 5'd0;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t             state_q;
    logic [4:0]         idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic [1:0]         sel_q;
    logic [47:0]        mac_q;
    logic [7:0]         arg_q;
    logic [7:0]         tx_byte_q;
    logic               tx_valid_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    function automatic logic [4:0] base_len(input logic [1:0] sel);
        case (sel)
            2'd0:    base_len = 5'd2;
            2'd1:    base_len = 5'd18;
            default: base_len = 5'd8;
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        hex_ascii = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] byte_at(input logic [1:0] sel, input logic [47:0] mac,
                                           input logic [7:0] arg, input logic [4:0] idx);
        logic [63:0] prefix;
        logic [4:0]  n;
        logic [3:0]  nib;
        case (sel)
            2'd0:    prefix = S_AT;
            2'd1:    prefix = S_CON;
            2'd2:    prefix = S_RESET;
            default: prefix = S_ROLE;
        endcase
        n   = idx - 5'd6;
        nib = 4'(mac >> {5'd11 - n, 2'b00});
        if (idx >= base_len(sel))
            byte_at = (idx == base_len(sel)) ? 8'h0D : 8'h0A;
        else if (sel == 2'd1 && idx >= 5'd6)
            byte_at = hex_ascii(nib);
        else if (sel == 2'd3 && idx == 5'd7)
            byte_at = arg;
        else
            byte_at = 8'(prefix >> {3'd7 - idx[2:0], 3'b000});
    endfunction

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign tx_byte   = tx_byte_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_arg   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 5'd0;
            gap_q      <= '0;
            sel_q      <= 2'd0;
            mac_q      <= 48'h0;
            arg_q      <= 8'h00;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        sel_q <= cmd_sel;
                        mac_q <= cmd_mac;
                        arg_q <= cmd_arg;
                        if (cmd_sel == 2'd3 && (cmd_arg < 8'h30 || cmd_arg > 8'h39)) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q    <= SEND;
                            idx_q      <= 5'd0;
                            tx_byte_q  <= byte_at(cmd_sel, cmd_mac, cmd_arg, 5'd0);
                            tx_valid_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx_q == base_len(sel_q) + CRLF_LEN - 5'd1) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= GAP;
                            gap_q      <= '0;
                            if (GAP_CYCLES == 0) done_q <= 1'b1;
                        end else begin
                            idx_q     <= idx_q + 5'd1;
                            tx_byte_q <= byte_at(sel_q, mac_q, arg_q, idx_q + 5'd1);
                        end
                    end
                end
                GAP: begin
                    // The done cycle still belongs to GAP so busy covers it and cmd_ready follows it.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                        if (gap_q == GAP_LAST) done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
